// File: rtl/imm_compressor.sv
// Packs 32-bit immediates onto a 16-bit valid/ready bus: sign-extended words go as one
// beat, all others as two beats (low half first). Keeps saturating narrow/wide counts.
module imm_compressor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             compress_en,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             out_narrow,
    output logic [CNT_W-1:0] narrow_cnt,
    output logic [CNT_W-1:0] wide_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] word;
    logic [31:0] word_nxt;
    logic        fits;
    logic        fits_nxt;
    logic        in_fits;
    logic        word_done;
    logic        accept;
    logic        narrow_inc;
    logic        wide_inc;

    // Final beat leaving this cycle frees the holding register for a zero-bubble refill.
    assign word_done  = out_valid && out_last && out_ready;
    assign in_ready   = rst_n && ((state == IDLE) || word_done);
    assign accept     = in_valid && in_ready;
    assign in_fits    = compress_en && (in_data[31:16] == {16{in_data[15]}});
    assign narrow_inc = (state == LO) && fits && out_ready;
    assign wide_inc   = (state == HI) && out_ready;

    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        fits_nxt  = fits;
        case (state)
            LO: begin
                if (out_ready) begin
                    state_nxt = fits ? IDLE : HI;
                end
            end
            HI: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
        if (accept) begin
            state_nxt = LO;
            word_nxt  = in_data;
            fits_nxt  = in_fits;
        end
    end

    // Outputs are registered from the next state so they always match the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word       <= '0;
            fits       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_narrow <= 1'b0;
            narrow_cnt <= '0;
            wide_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            word       <= word_nxt;
            fits       <= fits_nxt;
            out_valid  <= (state_nxt != IDLE);
            out_first  <= (state_nxt == LO);
            out_last   <= ((state_nxt == LO) && fits_nxt) || (state_nxt == HI);
            out_narrow <= (state_nxt == LO) && fits_nxt;
            case (state_nxt)
                LO:      out_data <= word_nxt[15:0];
                HI:      out_data <= word_nxt[31:16];
                default: out_data <= '0;
            endcase
            if (narrow_inc && (narrow_cnt != '1)) begin
                narrow_cnt <= narrow_cnt + CNT_W'(1);
            end
            if (wide_inc && (wide_cnt != '1)) begin
                wide_cnt <= wide_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/imm_compressor.md
Name: imm_compressor

Overview:
- Inverse of the datapath's 16->32 signed immediate extension.
- Accepts 32-bit words on a valid/ready input and emits them on a 16-bit valid/ready output bus.
- A word that is exactly the sign-extension of its low half is sent as one narrow beat. Any other word is sent as two beats, low half first.
- Sits between the instruction/constant generator and the 16-bit immediate store path. Keeps narrow/wide statistics.

Parameters:
- CNT_W, 16, width of the narrow_cnt and wide_cnt statistics counters (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- compress_en  input  1  1 = narrow encoding allowed; 0 = every word sent as two beats. Sampled only at input acceptance.
- in_data  input  32  word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  16  current output half-word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_first  output  1  current beat is the first beat of a word.
- out_last  output  1  current beat is the last beat of a word.
- out_narrow  output  1  word is narrow-encoded (single beat).
- narrow_cnt  output  CNT_W  count of words sent narrow; saturating.
- wide_cnt  output  CNT_W  count of words sent wide; saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; held word register=0; fits flag=0; counters=0.
  - out_valid=0, out_data=0, out_first=0, out_last=0, out_narrow=0.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- fits = compress_en AND (in_data[31:16] == {16{in_data[15]}}). Computed at acceptance and registered with the word.
- Input accept = in_valid AND in_ready.
- FSM states:
  - IDLE: out_valid=0; in_ready=1. On accept: capture word and fits; go to LO.
  - LO:
    - out_valid=1; out_data=word[15:0]; out_first=1; out_last=fits; out_narrow=fits.
    - If out_ready=0: hold all outputs and state (no change while stalled).
    - If out_ready=1 and fits=0: go to HI.
    - If out_ready=1 and fits=1: word complete.
  - HI:
    - out_valid=1; out_data=word[31:16]; out_first=0; out_last=1; out_narrow=0.
    - If out_ready=1: word complete.
- Output outputs are registered-state decodes; out_data is a mux of the held word. No combinational path from in_data to out_data.
- Word complete (final beat accepted):
  - in_ready=1 in that same cycle (in_ready = IDLE OR (out_last AND out_valid AND out_ready)).
  - If a word is accepted in that cycle: capture it and go to LO. This gives zero bubble, so narrow words stream at 1 word/cycle and wide words at 1 word/2 cycles.
  - If no word is accepted: go to IDLE.
- Latency: accepted word at edge N has its first beat valid in cycle N+1.
- Counters:
  - narrow_cnt increments when a narrow word's beat completes; wide_cnt increments when a wide word's HI beat completes.
  - Both hold at all-ones (saturate, no wrap).
- Boundary values:
  - 0x00007FFF and 0xFFFF8000 are narrow.
  - 0x00008000 and 0xFFFF7FFF are wide.
  - 0x00000000 and 0xFFFFFFFF are narrow.
- compress_en changing while a word is in flight has no effect on that word.
- in_valid deasserting without acceptance is legal; nothing is captured.
- Reset mid-word: the in-flight word is dropped, with no partial beat and no counter update. The bench must not expect recovery of the word.
- out_ready high while out_valid=0 is ignored.

Test Plan:
- Narrow negative: compress_en=1, in_data=0xFFFF8000, out_ready=1 -> one beat out_data=0x8000, first=1, last=1, narrow=1; narrow_cnt=1, wide_cnt=0.
- Wide boundary: in_data=0x00008000 -> beats 0x8000 (first=1, last=0, narrow=0) then 0x0000 (first=0, last=1); wide_cnt=1.
- Compression disabled: compress_en=0, in_data=0x00000005 -> two beats 0x0005 then 0x0000; wide_cnt increments and narrow_cnt does not.
- Backpressure: in_data=0x12345678, out_ready=0 for 3 cycles in LO and 2 cycles in HI.
  - out_data holds at 0x5678, then at 0x1234.
  - in_ready=0 throughout the stall.
  - Exactly 2 beats are delivered.
- Back-to-back streaming: 4 words {0x00000001, 0xFFFFFFFF, 0x00007FFF, 0xABCD0000} with in_valid continuously high and out_ready=1 -> out_data sequence 0x0001, 0xFFFF, 0x7FFF, 0x0000, 0xABCD over 5 consecutive cycles, no bubbles.
- Saturation and reset: CNT_W=2; send 5 narrow words -> narrow_cnt stays 3. Assert rst_n=0 mid-HI beat -> outputs and counters read 0 immediately, and the next beat after release belongs to a newly accepted word.
